// File: rtl/wb_stage.sv
// Writeback stage: selects ALU/load/link results and drives the registered register-file write port.
// Optional retired-instruction counter and `instret` port are enabled by defining WB_INSTRET_EN.
module wb_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rd,
    input  logic        in_rd_wen,
    input  logic [1:0]  in_sel,
    input  logic [31:0] in_alu_res,
    input  logic [31:0] in_pc,
    input  logic [2:0]  in_funct3,
    input  logic [1:0]  in_addr_lo,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [4:0]  waddr,
    output logic        wen,
    output logic [31:0] wdata,
    output logic        retire
`ifdef WB_INSTRET_EN
    ,
    output logic [63:0] instret
`endif
);

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } state_t;

    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_LINK = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    state_t      r_state;
    state_t      w_state_next;

    logic [4:0]  r_ld_rd;
    logic        r_ld_rd_wen;
    logic [2:0]  r_ld_funct3;
    logic [1:0]  r_ld_addr_lo;

    logic [4:0]  r_waddr;
    logic        r_wen;
    logic [31:0] r_wdata;
    logic        r_retire;

    logic        w_fire;
    logic        w_latch_load;
    logic        w_done;
    logic [4:0]  w_done_rd;
    logic        w_done_rd_wen;
    logic [31:0] w_done_data;

    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;
    logic [31:0] w_load_data;

    assign in_ready = (r_state == IDLE);
    assign w_fire   = in_valid && in_ready;

    // Lane selection uses the address bits captured at acceptance, not the live inputs.
    always_comb begin : load_extract
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_ld_byte   = mem_rdata[7:0];
        w_ld_half   = mem_rdata[15:0];
        w_load_data = mem_rdata;

        case (r_ld_addr_lo)
            2'd1:    w_ld_byte = mem_rdata[15:8];
            2'd2:    w_ld_byte = mem_rdata[23:16];
            2'd3:    w_ld_byte = mem_rdata[31:24];
            default: w_ld_byte = mem_rdata[7:0];
        endcase

        if (r_ld_addr_lo[1]) begin
            w_ld_half = mem_rdata[31:16];
        end

        case (r_ld_funct3)
            F3_LB:   w_load_data = {{24{w_ld_byte[7]}}, w_ld_byte};
            F3_LH:   w_load_data = {{16{w_ld_half[15]}}, w_ld_half};
            F3_LBU:  w_load_data = {24'd0, w_ld_byte};
            F3_LHU:  w_load_data = {16'd0, w_ld_half};
            default: w_load_data = mem_rdata;
        endcase
    end

    always_comb begin : fsm_next
        w_state_next  = r_state;
        w_latch_load  = 1'b0;
        w_done        = 1'b0;
        w_done_rd     = in_rd;
        w_done_rd_wen = in_rd_wen;
        w_done_data   = in_alu_res;

        case (r_state)
            IDLE: begin
                if (w_fire) begin
                    if (in_sel == SEL_LOAD) begin
                        w_latch_load = 1'b1;
                        w_state_next = WAIT_LOAD;
                    end else begin
                        w_done = 1'b1;
                        if (in_sel == SEL_LINK) begin
                            w_done_data = in_pc + 32'd4;
                        end
                    end
                end
            end
            WAIT_LOAD: begin
                if (mem_rvalid) begin
                    w_done        = 1'b1;
                    w_done_rd     = r_ld_rd;
                    w_done_rd_wen = r_ld_rd_wen;
                    w_done_data   = w_load_data;
                    w_state_next  = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ld_rd      <= '0;
            r_ld_rd_wen  <= 1'b0;
            r_ld_funct3  <= '0;
            r_ld_addr_lo <= '0;
        end else if (w_latch_load) begin
            r_ld_rd      <= in_rd;
            r_ld_rd_wen  <= in_rd_wen;
            r_ld_funct3  <= in_funct3;
            r_ld_addr_lo <= in_addr_lo;
        end
    end

    // Address and data follow every completion; only the enable is masked for x0 or no-write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_waddr  <= '0;
            r_wen    <= 1'b0;
            r_wdata  <= '0;
            r_retire <= 1'b0;
        end else begin
            r_wen    <= w_done && w_done_rd_wen && (w_done_rd != 5'd0);
            r_retire <= w_done;
            if (w_done) begin
                r_waddr <= w_done_rd;
                r_wdata <= w_done_data;
            end
        end
    end

    assign waddr  = r_waddr;
    assign wen    = r_wen;
    assign wdata  = r_wdata;
    assign retire = r_retire;

`ifdef WB_INSTRET_EN
    logic [63:0] r_instret;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instret <= '0;
        end else if (w_done) begin
            r_instret <= r_instret + 64'd1;
        end
    end

    assign instret = r_instret;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: scoreboard of expected writes, compared on each retire pulse.
// Define WB_INSTRET_EN for both files to also check the retired-instruction counter.
module tb_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic        in_rd_wen;
    logic [1:0]  in_sel;
    logic [31:0] in_alu_res;
    logic [31:0] in_pc;
    logic [2:0]  in_funct3;
    logic [1:0]  in_addr_lo;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [4:0]  waddr;
    logic        wen;
    logic [31:0] wdata;
    logic        retire;
`ifdef WB_INSTRET_EN
    logic [63:0] instret;
`endif

    wb_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rd      (in_rd),
        .in_rd_wen  (in_rd_wen),
        .in_sel     (in_sel),
        .in_alu_res (in_alu_res),
        .in_pc      (in_pc),
        .in_funct3  (in_funct3),
        .in_addr_lo (in_addr_lo),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .waddr      (waddr),
        .wen        (wen),
        .wdata      (wdata),
        .retire     (retire)
`ifdef WB_INSTRET_EN
        ,
        .instret    (instret)
`endif
    );

    typedef struct {
        logic [4:0]  waddr;
        logic        wen;
        logic [31:0] wdata;
    } wb_exp_t;

    wb_exp_t sb[$];
    int      checks       = 0;
    int      failures     = 0;
    int      exp_retired  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference load extraction written from the load-size table with shifts.
    function automatic logic [31:0] load_model(input logic [31:0] word, input logic [2:0] f3,
                                               input logic [1:0] alo);
        logic [31:0] b;
        logic [31:0] h;
        b = (word >> (8 * alo)) & 32'h0000_00FF;
        h = (word >> (alo[1] ? 16 : 0)) & 32'h0000_FFFF;
        case (f3)
            3'b000:  return b[7]  ? (b | 32'hFFFF_FF00) : b;
            3'b001:  return h[15] ? (h | 32'hFFFF_0000) : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return word;
        endcase
    endfunction

    // Monitor: every retire pops one expectation; no write may appear without a retire.
    initial begin
        wb_exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (retire) begin
                    if (sb.size() == 0) begin
                        check("unexpected_retire", retire, 1'b0);
                    end else begin
                        e = sb.pop_front();
                        check("waddr", waddr, e.waddr);
                        check("wen", wen, e.wen);
                        check("wdata", wdata, e.wdata);
                    end
                end else begin
                    check("wen_without_retire", wen, 1'b0);
                end
            end
        end
    end

    // Presents one instruction at a negedge and returns at the negedge after its acceptance edge,
    // leaving in_valid asserted so the caller can chain the next instruction back-to-back.
    task automatic send(input logic [1:0] sel, input logic [4:0] rd, input logic rd_wen,
                        input logic [31:0] alu, input logic [31:0] pc, input logic [2:0] f3,
                        input logic [1:0] alo, input logic [31:0] rdata, output int waited);
        wb_exp_t e;
        in_valid   = 1'b1;
        in_sel     = sel;
        in_rd      = rd;
        in_rd_wen  = rd_wen;
        in_alu_res = alu;
        in_pc      = pc;
        in_funct3  = f3;
        in_addr_lo = alo;
        waited     = 0;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("accept_timeout", in_ready, 1'b1);
            in_valid = 1'b0;
            return;
        end
        e.waddr = rd;
        e.wen   = rd_wen && (rd != 5'd0);
        case (sel)
            2'b01:   e.wdata = load_model(rdata, f3, alo);
            2'b10:   e.wdata = pc + 32'd4;
            default: e.wdata = alu;
        endcase
        sb.push_back(e);
        exp_retired++;
        @(negedge clk);
        if (sel != 2'b01) begin
            check("alu_latency_retire", retire, 1'b1);
        end
    endtask

    task automatic alu(input logic [1:0] sel, input logic [4:0] rd, input logic rd_wen,
                       input logic [31:0] val, input logic [31:0] pc);
        int w;
        send(sel, rd, rd_wen, val, pc, 3'b000, 2'b00, 32'h0, w);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [4:0] rd, input logic rd_wen, input logic [2:0] f3,
                        input logic [1:0] alo, input logic [31:0] rdata, input int delay,
                        input bit keep_valid);
        int w;
        send(2'b01, rd, rd_wen, $urandom, $urandom, f3, alo, rdata, w);
        in_valid = keep_valid;
        for (int i = 0; i < delay; i++) begin
            check("stall_ready", in_ready, 1'b0);
            check("stall_no_retire", retire, 1'b0);
            mem_rdata = $urandom;
            @(negedge clk);
        end
        check("wait_ready", in_ready, 1'b0);
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        check("ready_after_rsp", in_ready, 1'b1);
        check("load_retire", retire, 1'b1);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int w;

        rst_n      = 1'b0;
        in_valid   = 1'b1;
        in_rd      = 5'd7;
        in_rd_wen  = 1'b1;
        in_sel     = 2'b00;
        in_alu_res = 32'h1234_5678;
        in_pc      = 32'h0;
        in_funct3  = 3'b000;
        in_addr_lo = 2'b00;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;

        repeat (3) @(negedge clk);
        check("rst_wen", wen, 1'b0);
        check("rst_waddr", waddr, 5'd0);
        check("rst_wdata", wdata, 32'h0);
        check("rst_retire", retire, 1'b0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_wen_after", wen, 1'b0);
`ifdef WB_INSTRET_EN
        check("rst_instret", instret, 64'd0);
`endif

        // ALU, x0, link wrap, reserved select, no-write flag.
        alu(2'b00, 5'd5, 1'b1, 32'hDEAD_BEEF, 32'h0);
        idle(1);
        check("wen_one_cycle", wen, 1'b0);
        alu(2'b00, 5'd0, 1'b1, 32'hCAFE_F00D, 32'h0);
        idle(1);
        alu(2'b10, 5'd1, 1'b1, 32'h1111_1111, 32'hFFFF_FFFC);
        alu(2'b11, 5'd9, 1'b1, 32'hA5A5_5A5A, 32'h0000_1000);
        alu(2'b00, 5'd12, 1'b0, 32'h0BAD_0BAD, 32'h0);
        idle(2);

        // Back-to-back throughput.
        for (int i = 0; i < 4; i++) begin
            alu(2'b00, 5'(i + 20), 1'b1, $urandom, $urandom);
        end
        idle(2);

        // Loads across sizes, lanes and response delays.
        load(5'd3, 1'b1, 3'b000, 2'd2, 32'h80FF_7F01, 0, 1'b0);
        load(5'd4, 1'b1, 3'b100, 2'd2, 32'h80FF_7F01, 1, 1'b0);
        load(5'd6, 1'b1, 3'b001, 2'd3, 32'h80FF_7F01, 2, 1'b0);
        load(5'd8, 1'b1, 3'b010, 2'd0, 32'h80FF_7F01, 0, 1'b0);
        load(5'd10, 1'b1, 3'b101, 2'd1, 32'h80FF_7F01, 1, 1'b0);
        load(5'd11, 1'b1, 3'b000, 2'd1, 32'h1234_8001, 0, 1'b0);
        load(5'd13, 1'b1, 3'b011, 2'd3, 32'h7654_3210, 0, 1'b0);
        load(5'd0, 1'b1, 3'b010, 2'd0, 32'hFFFF_FFFF, 0, 1'b0);
        idle(1);

        // Long stall with upstream holding valid, then next instruction on the following edge.
        load(5'd14, 1'b1, 3'b001, 2'd0, 32'h0000_8123, 4, 1'b1);
        send(2'b00, 5'd15, 1'b1, 32'h5555_AAAA, 32'h0, 3'b000, 2'b00, 32'h0, w);
        check("accept_after_load", w, 0);
        idle(1);

        // Spurious response while idle.
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFF_FFFF;
        @(negedge clk);
        check("spurious_no_retire", retire, 1'b0);
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("spurious_ready", in_ready, 1'b1);
        idle(2);
        check("sb_drained", sb.size(), 0);
`ifdef WB_INSTRET_EN
        check("instret_count", instret, 64'(exp_retired));
`endif

        // Reset during WAIT_LOAD discards the pending load.
        send(2'b01, 5'd17, 1'b1, 32'h0, 32'h0, 3'b010, 2'b00, 32'h1357_9BDF, w);
        in_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_wait", in_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_ready", in_ready, 1'b1);
        check("midrst_wen", wen, 1'b0);
        check("midrst_waddr", waddr, 5'd0);
        check("midrst_wdata", wdata, 32'h0);
`ifdef WB_INSTRET_EN
        check("midrst_instret", instret, 64'd0);
`endif
        void'(sb.pop_back());
        exp_retired = 0;
        @(negedge clk);
        rst_n = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1357_9BDF;
        @(negedge clk);
        check("late_rvalid_no_retire", retire, 1'b0);
        mem_rvalid = 1'b0;
        @(negedge clk);
        check("late_rvalid_no_wen", wen, 1'b0);

        alu(2'b00, 5'd31, 1'b1, 32'h0F0F_F0F0, 32'h0);
        idle(2);
        check("final_sb_drained", sb.size(), 0);
`ifdef WB_INSTRET_EN
        check("final_instret", instret, 64'(exp_retired));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
